// File: rtl/rot_pos_tracker.sv
`default_nettype none
// ============================================================================
// Module  : rot_pos_tracker
// Purpose : Synchronises, decodes and debounces a rotary position code and
//           reports steps, skips, a signed step count and a compass LED.
// Rev     : 1.0  initial release
// ============================================================================
module rot_pos_tracker #(
    parameter int POS_W       = 3,
    parameter int CNT_W       = 8,
    parameter int DEBOUNCE    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             prog_select,
    input  logic [POS_W-1:0] bin_rot,
    input  logic [POS_W-1:0] gray_rot,
    input  logic             clr_count,
    output logic [POS_W-1:0] position,
    output logic             valid,
    output logic [3:0]       led,
    output logic             step_cw,
    output logic             step_ccw,
    output logic             skip_err,
    output logic [CNT_W-1:0] step_count
);

    localparam int             DB_W    = $clog2(DEBOUNCE + 1);
    localparam logic [DB_W-1:0] DB_FULL = DB_W'(DEBOUNCE);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] CNT_MIN = {1'b1, {(CNT_W-1){1'b0}}};

    logic                   sel_q;
    logic [POS_W-1:0]       sync_q [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] fill_q;
    logic [POS_W-1:0]       cand_q, cand_d;
    logic [DB_W-1:0]        stab_q, stab_d;
    logic [POS_W-1:0]       pos_q, pos_d;
    logic                   valid_q, valid_d;
    logic [3:0]             led_q, led_d;
    logic                   cw_q, cw_d, ccw_q, ccw_d, skip_q, skip_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic                   w_restart;
    logic [POS_W-1:0]       w_src, w_code, w_gray_bin, w_dec, w_delta;
    logic                   w_accept;

    assign w_restart = (prog_select != sel_q);
    assign w_src     = prog_select ? bin_rot : gray_rot;
    assign w_code    = sync_q[SYNC_STAGES-1];

    // Each binary bit is the XOR of all Gray bits at and above it.
    for (genvar gi = 0; gi < POS_W; gi++) begin : g_gray2bin
        assign w_gray_bin[gi] = ^(w_code >> gi);
    end

    assign w_dec = sel_q ? w_code : w_gray_bin;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sel_q <= prog_select;
        end else if (w_restart) begin
            sel_q <= prog_select;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || w_restart) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            fill_q <= '0;
            cand_q <= '0;
            stab_q <= '0;
        end else begin
            sync_q[0] <= w_src;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            cand_q <= cand_d;
            stab_q <= stab_d;
        end
    end

    // Debounce only counts codes that made it through a freshly filled synchroniser.
    always_comb begin
        cand_d   = cand_q;
        stab_d   = stab_q;
        w_accept = 1'b0;
        if (fill_q[SYNC_STAGES-1]) begin
            if ((stab_q != '0) && (w_dec == cand_q)) begin
                if (stab_q != DB_FULL) begin
                    stab_d   = stab_q + 1'b1;
                    w_accept = (stab_q == DB_LAST);
                end
            end else begin
                cand_d   = w_dec;
                stab_d   = DB_W'(1);
                w_accept = (DEBOUNCE == 1);
            end
        end
    end

    assign w_delta = w_dec - pos_q;

    always_comb begin
        pos_d   = pos_q;
        valid_d = valid_q;
        cw_d    = 1'b0;
        ccw_d   = 1'b0;
        skip_d  = 1'b0;
        if (w_restart) begin
            valid_d = 1'b0;
        end else if (w_accept) begin
            pos_d   = w_dec;
            valid_d = 1'b1;
            if (valid_q) begin
                if (w_delta == POS_W'(1)) begin
                    cw_d = 1'b1;
                end else if (w_delta == '1) begin
                    ccw_d = 1'b1;
                end else if (w_delta != '0) begin
                    skip_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_count) begin
            cnt_d = '0;
        end else if (cw_d && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end else if (ccw_d && (cnt_q != CNT_MIN)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_comb begin
        led_d = 4'b0000;
        if (valid_d) begin
            case (pos_d[POS_W-1 -: 3])
                3'd0:    led_d = 4'b0001;
                3'd1:    led_d = 4'b0011;
                3'd2:    led_d = 4'b0010;
                3'd3:    led_d = 4'b0110;
                3'd4:    led_d = 4'b0100;
                3'd5:    led_d = 4'b1100;
                3'd6:    led_d = 4'b1000;
                default: led_d = 4'b1001;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pos_q   <= '0;
            valid_q <= 1'b0;
            led_q   <= 4'b0000;
            cw_q    <= 1'b0;
            ccw_q   <= 1'b0;
            skip_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pos_q   <= pos_d;
            valid_q <= valid_d;
            led_q   <= led_d;
            cw_q    <= cw_d;
            ccw_q   <= ccw_d;
            skip_q  <= skip_d;
            cnt_q   <= cnt_d;
        end
    end

    assign position   = pos_q;
    assign valid      = valid_q;
    assign led        = led_q;
    assign step_cw    = cw_q;
    assign step_ccw   = ccw_q;
    assign skip_err   = skip_q;
    assign step_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rot_pos_tracker.sv
`default_nettype none
// ============================================================================
// Module  : tb_rot_pos_tracker
// Purpose : Directed and randomized self-checking bench for rot_pos_tracker.
// Rev     : 1.0  initial release
// ============================================================================
module tb_rot_pos_tracker;

    localparam int POS_W = 3;
    localparam int CNT_W = 8;
    localparam int DB    = 4;
    localparam int SS    = 2;
    localparam int NPOS  = 1 << POS_W;
    localparam int CMAX  = (1 << (CNT_W-1)) - 1;
    localparam int CMIN  = -(1 << (CNT_W-1));

    logic             clk = 1'b0;
    logic             reset_n, prog_select, clr_count;
    logic [POS_W-1:0] bin_rot, gray_rot;
    logic [POS_W-1:0] position;
    logic             valid, step_cw, step_ccw, skip_err;
    logic [3:0]       led;
    logic [CNT_W-1:0] step_count;

    int checks   = 0;
    int failures = 0;

    rot_pos_tracker #(
        .POS_W(POS_W), .CNT_W(CNT_W), .DEBOUNCE(DB), .SYNC_STAGES(SS)
    ) dut (
        .clk(clk), .reset_n(reset_n), .prog_select(prog_select),
        .bin_rot(bin_rot), .gray_rot(gray_rot), .clr_count(clr_count),
        .position(position), .valid(valid), .led(led),
        .step_cw(step_cw), .step_ccw(step_ccw), .skip_err(skip_err),
        .step_count(step_count)
    );

    always #5 clk = ~clk;

    function automatic logic [POS_W-1:0] b2g(input int b);
        logic [POS_W-1:0] v;
        v = POS_W'(b);
        return v ^ (v >> 1);
    endfunction

    function automatic int g2b(input logic [POS_W-1:0] g);
        int b;
        b = 0;
        for (int i = 0; i < POS_W; i++) b = b ^ (int'(g) >> i);
        return b;
    endfunction

    logic [3:0] ledtab [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                               4'b0100, 4'b1100, 4'b1000, 4'b1001};

    // Reference model: accept a code when the input history shows a run of
    // exactly DB equal samples, SS edges old, all taken after the last restart.
    int cyc = 0, restart = 0, m_pos = 0, m_cnt = 0;
    bit m_valid = 0, m_sel = 0, e_cw = 0, e_ccw = 0, e_skip = 0;
    int hist [64];

    always @(posedge clk) begin
        int first, last, v, d;
        bit run;
        cyc++;
        hist[cyc % 64] = prog_select ? int'(bin_rot) : g2b(gray_rot);
        e_cw = 0; e_ccw = 0; e_skip = 0;
        if (!reset_n) begin
            m_pos = 0; m_valid = 0; m_cnt = 0; m_sel = prog_select; restart = cyc;
        end else if (prog_select != m_sel) begin
            m_sel = prog_select; m_valid = 0; restart = cyc;
            if (clr_count) m_cnt = 0;
        end else begin
            last  = cyc - SS;
            first = last - DB + 1;
            run   = (first > restart);
            if (run) begin
                v = hist[last % 64];
                for (int k = first; k <= last; k++)
                    if (hist[k % 64] != v) run = 0;
                if ((first - 1 > restart) && (hist[(first - 1) % 64] == v)) run = 0;
            end
            if (run) begin
                if (m_valid) begin
                    d = (((v - m_pos) % NPOS) + NPOS) % NPOS;
                    if (d == 1) e_cw = 1;
                    else if (d == NPOS - 1) e_ccw = 1;
                    else if (d != 0) e_skip = 1;
                end
                m_pos = v; m_valid = 1;
            end
            if (clr_count) m_cnt = 0;
            else if (e_cw && m_cnt < CMAX) m_cnt++;
            else if (e_ccw && m_cnt > CMIN) m_cnt--;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 0; prog_select = 0; clr_count = 0; bin_rot = '0; gray_rot = 3'b011;
        tick(); tick();
        checks++;
        if ({valid, led, step_count, position} !== {1'b0, 4'b0000, 8'h00, 3'd0}) begin
            failures++;
            $display("FAIL reset_state got v=%b led=%b cnt=%h pos=%0d want v=0 led=0000 cnt=00 pos=0",
                     valid, led, step_count, position);
        end
        reset_n = 1;
        repeat (5) tick();
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_early_valid got %b want 0", valid);
        end
        tick();
        checks++;
        if ({valid, position, led, step_cw, step_ccw, skip_err} !== {1'b1, 3'd2, 4'b0010, 3'b000}) begin
            failures++;
            $display("FAIL reset_first_accept got v=%b pos=%0d led=%b pulses=%b%b%b want v=1 pos=2 led=0010 pulses=000",
                     valid, position, led, step_cw, step_ccw, skip_err);
        end
    endtask

    task automatic test_cw();
        gray_rot = 3'b000; repeat (8) tick();
        gray_rot = 3'b001;
        repeat (5) tick();
        checks++;
        if ({step_cw, position} !== {1'b0, 3'd0}) begin
            failures++;
            $display("FAIL cw_early got cw=%b pos=%0d want cw=0 pos=0", step_cw, position);
        end
        tick();
        checks++;
        if ({step_cw, step_ccw, skip_err, position, led, step_count} !== {3'b100, 3'd1, 4'b0011, 8'h01}) begin
            failures++;
            $display("FAIL cw_step got pulses=%b%b%b pos=%0d led=%b cnt=%h want 100 1 0011 01",
                     step_cw, step_ccw, skip_err, position, led, step_count);
        end
        tick();
        checks++;
        if (step_cw !== 1'b0) begin
            failures++;
            $display("FAIL cw_single_cycle got %b want 0", step_cw);
        end
    endtask

    task automatic test_ccw();
        gray_rot = 3'b000; repeat (8) tick();
        gray_rot = 3'b100;
        repeat (6) tick();
        checks++;
        if ({step_cw, step_ccw, skip_err, position, led, step_count} !== {3'b010, 3'd7, 4'b1001, 8'hFF}) begin
            failures++;
            $display("FAIL ccw_wrap got pulses=%b%b%b pos=%0d led=%b cnt=%h want 010 7 1001 FF",
                     step_cw, step_ccw, skip_err, position, led, step_count);
        end
        gray_rot = 3'b000; repeat (8) tick();
        checks++;
        if ({position, step_count} !== {3'd0, 8'h00}) begin
            failures++;
            $display("FAIL cw_wrap got pos=%0d cnt=%h want 0 00", position, step_count);
        end
    endtask

    task automatic test_glitch_skip();
        bit bad;
        bad = 0;
        gray_rot = 3'b001; repeat (3) tick();
        gray_rot = 3'b000;
        repeat (10) begin
            tick();
            if (step_cw || step_ccw || skip_err || position !== 3'd0) bad = 1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL glitch_reject got an event or pos=%0d want quiet pos=0", position);
        end
        gray_rot = 3'b011;
        repeat (6) tick();
        checks++;
        if ({step_cw, step_ccw, skip_err, position, led, step_count} !== {3'b001, 3'd2, 4'b0010, 8'h00}) begin
            failures++;
            $display("FAIL skip_err got pulses=%b%b%b pos=%0d led=%b cnt=%h want 001 2 0010 00",
                     step_cw, step_ccw, skip_err, position, led, step_count);
        end
        gray_rot = 3'b000; repeat (8) tick();
    endtask

    task automatic test_saturation();
        for (int k = 1; k <= 127; k++) begin
            gray_rot = b2g(k % NPOS);
            repeat (7) tick();
        end
        checks++;
        if (step_count !== 8'd127) begin
            failures++;
            $display("FAIL sat_reach got cnt=%h want 7F", step_count);
        end
        gray_rot = b2g(0);
        repeat (6) tick();
        checks++;
        if ({step_cw, step_count} !== {1'b1, 8'd127}) begin
            failures++;
            $display("FAIL sat_hold got cw=%b cnt=%h want cw=1 cnt=7F", step_cw, step_count);
        end
        gray_rot = b2g(1);
        repeat (5) tick();
        clr_count = 1;
        tick();
        clr_count = 0;
        checks++;
        if ({step_cw, step_count} !== {1'b1, 8'd0}) begin
            failures++;
            $display("FAIL clr_priority got cw=%b cnt=%h want cw=1 cnt=00", step_cw, step_count);
        end
        repeat (2) tick();
    endtask

    task automatic test_mode();
        int n;
        bin_rot = 3'b101; prog_select = 1;
        tick();
        checks++;
        if ({valid, led, position, step_count} !== {1'b0, 4'b0000, 3'd1, 8'h00}) begin
            failures++;
            $display("FAIL mode_clear got v=%b led=%b pos=%0d cnt=%h want 0 0000 1 00",
                     valid, led, position, step_count);
        end
        n = 0;
        while (valid !== 1'b1 && n < 12) begin tick(); n++; end
        checks++;
        if ({valid, position, led, step_cw, step_ccw, skip_err, step_count} !==
            {1'b1, 3'd5, 4'b1100, 3'b000, 8'h00}) begin
            failures++;
            $display("FAIL mode_accept got v=%b pos=%0d led=%b pulses=%b%b%b cnt=%h after %0d edges want 1 5 1100 000 00",
                     valid, position, led, step_cw, step_ccw, skip_err, step_count, n);
        end
        prog_select = 0;
        repeat (10) tick();
    endtask

    task automatic test_reset_mid();
        gray_rot = b2g(3);
        repeat (3) tick();
        reset_n = 0;
        tick();
        reset_n = 1;
        checks++;
        if ({valid, position, led, step_count, step_cw, step_ccw, skip_err} !==
            {1'b0, 3'd0, 4'b0000, 8'h00, 3'b000}) begin
            failures++;
            $display("FAIL reset_mid got v=%b pos=%0d led=%b cnt=%h want all zero",
                     valid, position, led, step_count);
        end
        repeat (6) tick();
        checks++;
        if ({valid, position, led, step_cw, step_ccw, skip_err} !== {1'b1, 3'd3, 4'b0110, 3'b000}) begin
            failures++;
            $display("FAIL reset_mid_reaccept got v=%b pos=%0d led=%b pulses=%b%b%b want 1 3 0110 000",
                     valid, position, led, step_cw, step_ccw, skip_err);
        end
    endtask

    task automatic test_random();
        int cg, cb, r;
        logic [3:0] el;
        cg = 3; cb = 0;
        for (int i = 0; i < 2500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 12) cg = (cg + 1) % NPOS;
            else if (r < 20) cg = (cg + NPOS - 1) % NPOS;
            else if (r < 23) cg = $urandom_range(0, NPOS - 1);
            r = $urandom_range(0, 99);
            if (r < 10) cb = (cb + 1) % NPOS;
            else if (r < 16) cb = (cb + NPOS - 1) % NPOS;
            else if (r < 18) cb = $urandom_range(0, NPOS - 1);
            gray_rot    = b2g(cg);
            bin_rot     = POS_W'(cb);
            clr_count   = ($urandom_range(0, 59) == 0);
            reset_n     = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 149) == 0) prog_select = ~prog_select;
            tick();
            el = m_valid ? ledtab[m_pos >> (POS_W - 3)] : 4'b0000;
            checks++;
            if (position !== POS_W'(m_pos)) begin
                failures++;
                $display("FAIL rnd_position cyc=%0d got %0d want %0d", cyc, position, m_pos);
            end
            checks++;
            if (valid !== m_valid) begin
                failures++;
                $display("FAIL rnd_valid cyc=%0d got %b want %b", cyc, valid, m_valid);
            end
            checks++;
            if (led !== el) begin
                failures++;
                $display("FAIL rnd_led cyc=%0d got %b want %b", cyc, led, el);
            end
            checks++;
            if ({step_cw, step_ccw, skip_err} !== {e_cw, e_ccw, e_skip}) begin
                failures++;
                $display("FAIL rnd_pulses cyc=%0d got %b%b%b want %b%b%b", cyc,
                         step_cw, step_ccw, skip_err, e_cw, e_ccw, e_skip);
            end
            checks++;
            if (step_count !== CNT_W'(m_cnt)) begin
                failures++;
                $display("FAIL rnd_count cyc=%0d got %h want %h", cyc, step_count, CNT_W'(m_cnt));
            end
        end
        reset_n = 1; clr_count = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_cw();
        test_ccw();
        test_glitch_skip();
        test_saturation();
        test_mode();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rot_pos_tracker.md
ROT_POS_TRACKER -- requirements
Module: rot_pos_tracker

Interface
REQ-001 Parameter POS_W, default 3, position code width in bits; SHALL be >= 3.
REQ-002 Parameter CNT_W, default 8, width of the signed step counter.
REQ-003 Parameter DEBOUNCE, default 4, consecutive stable cycles required to accept a code; SHALL be >= 1.
REQ-004 Parameter SYNC_STAGES, default 2, synchroniser flops per input bit; SHALL be >= 2.
REQ-005 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-006 reset_n  in  1  reset, synchronous, active-low.
REQ-007 prog_select  in  1  mode: 1 = bin_rot is the source (plain binary), 0 = gray_rot is the source (reflected Gray).
REQ-008 bin_rot  in  POS_W  asynchronous binary position code.
REQ-009 gray_rot  in  POS_W  asynchronous reflected-Gray position code.
REQ-010 clr_count  in  1  synchronous clear of step_count.
REQ-011 position  out  POS_W  accepted binary position.
REQ-012 valid  out  1  high once a position has been accepted since reset or mode change.
REQ-013 led  out  4  compass pattern for the accepted position.
REQ-014 step_cw, step_ccw, skip_err  out  1 each  single-cycle event pulses.
REQ-015 step_count  out  CNT_W  signed net step count, two's complement.

Function
REQ-016 Each bit of the source selected by prog_select SHALL pass through a SYNC_STAGES-deep synchroniser; the unselected source SHALL be ignored.
REQ-017 Gray mode SHALL convert the synchronised code to binary (b[MSB]=g[MSB]; b[i]=b[i+1] XOR g[i]); binary mode SHALL use the code unchanged.
REQ-018 Debounce: a decoded code SHALL be accepted only after it is equal on DEBOUNCE consecutive edges; any change restarts the count.
REQ-019 Latency: an input change held stable between edges 0 and 1 SHALL update position, led and pulses at edge SYNC_STAGES+DEBOUNCE (6 at defaults).
REQ-020 First acceptance after reset or mode change: position SHALL load, valid SHALL rise, and no step/skip pulse or count change SHALL occur.
REQ-021 Subsequent acceptance of a code different from position: delta = (new - position) mod 2^POS_W.
REQ-022 delta == 1: step_cw pulse, step_count +1.
REQ-023 delta == 2^POS_W-1: step_ccw pulse, step_count -1.
REQ-024 Any other nonzero delta: skip_err pulse, position updates, step_count unchanged.
REQ-025 Wrap-around (max -> 0 is CW, 0 -> max is CCW) SHALL follow REQ-022/023.
REQ-026 step_count SHALL saturate at +2^(CNT_W-1)-1 and -2^(CNT_W-1); a step into saturation still pulses.
REQ-027 clr_count SHALL zero step_count next edge and take priority over a coincident step.
REQ-028 A prog_select change SHALL within one edge clear valid, force led to 0000 and restart synchroniser/debounce; position and step_count SHALL hold.
REQ-029 led SHALL follow sector s = position[POS_W-1:POS_W-3]: 0 N 0001, 1 NE 0011, 2 E 0010, 3 SE 0110, 4 S 0100, 5 SW 1100, 6 W 1000, 7 NW 1001; led SHALL be 0000 while valid is 0.
REQ-030 All outputs SHALL be registered; at most one of step_cw, step_ccw, skip_err SHALL be high in any cycle.

Reset
REQ-031 With reset_n low at an edge: position 0, valid 0, led 0000, all pulses 0, step_count 0, synchronisers and debounce cleared.
REQ-032 Reset asserted mid-debounce or mid-pulse SHALL abort and discard that acceptance.
REQ-033 After release, behaviour SHALL follow REQ-020.

Verification (defaults POS_W=3, DEBOUNCE=4, SYNC_STAGES=2)
REQ-034 reset_n=0 for 2 cycles, gray_rot=011 -> led 0000, valid 0, step_count 0; release -> at edge 6 position 2, led 0010, valid 1, no pulse.
REQ-035 Gray mode, accepted 000, gray_rot->001 -> edge 6: step_cw 1 cycle, position 1, led 0011, step_count 1.
REQ-036 Accepted 000, gray_rot->100 -> step_ccw, position 7, led 1001, step_count -1 (8'hFF).
REQ-037 Accepted 000, gray_rot pulses 001 for 3 cycles then 000 -> no pulse, position 0; gray_rot->011 held -> skip_err, position 2, count unchanged.
REQ-038 step_count at +127 plus a CW step -> step_cw, count stays 127; clr_count coincident with a step -> count 0.
REQ-039 prog_select 0->1 with bin_rot=101 -> led 0000, valid 0 next edge; then position 5, led 1100, valid 1, no pulse.
